viterbi_traceback: RTL and testbench

Traceback reader for the Viterbi decoder survivor memory. The ACS unit writes one decision word per trellis stage into the dual-address storage RAM; this block reads those words backwards from a given end state and reconstructs the decoded bits. A bit LIFO reverses the traced sequence so bits leave in forward time order on a valid/ready stream.

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/tb_bit_lifo.sv | 41 ++++
 rtl/viterbi_traceback.sv | 165 ++++++++++++++++
 tb/tb_viterbi_traceback.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi traceback types: trellis state, decision word, FSM encoding
// and the backward-step (predecessor) rule.
package viterbi_pkg;

  localparam int K          = 4;
  localparam int NUM_STATES = 2**(K-1);

  typedef logic [K-2:0]          state_t;
  typedef logic [NUM_STATES-1:0] dec_word_t;

  typedef enum logic [1:0] {IDLE, TRACE, DRAIN, OUTPUT} tb_state_e;

  // Next state is {u, s[K-2:1]}, so stepping back shifts left and refills
  // the LSB with the survivor decision stored for that state.
  function automatic state_t predecessor(input state_t s, input dec_word_t w);
    return {s[K-3:0], w[s]};
  endfunction

endpackage

// File: rtl/tb_bit_lifo.sv
// Single-bit LIFO used to reverse the traced bit order; depth must be a power of two.
module tb_bit_lifo #(
  parameter int  DEPTH = 64,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          bit_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          top_o
);

  logic [DEPTH-1:0] mem_q;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-2:0]    top_idx;

  assign top_idx = count_q[CW-2:0] - 1'b1;
  assign top_o   = mem_q[top_idx];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (push_i)     count_d = count_q + 1'b1;
    else if (pop_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Storage is not reset: only the pointer decides what is visible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[count_q[CW-2:0]] <= bit_i;
  end

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi survivor-memory traceback reader with bit-order reversal on a valid/ready stream.
// Optional: define VITERBI_TB_START_CHK_EN to add start_err (nonzero final traced state).
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  state_t                start_state,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [ADDR_WIDTH:0]   frame_len,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  input  dec_word_t             rd_data,
  output logic                  dec_bit,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic                  dec_last
`ifdef VITERBI_TB_START_CHK_EN
  ,
  output logic                  start_err
`endif
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam int                LW      = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]     MAX_LEN = LW'(DEPTH);

  tb_state_e             state_q, state_d;
  state_t                cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic                  rd_vld_q;
  logic                  dec_bit_q, dec_bit_d;
  logic                  dec_valid_q, dec_valid_d;
  logic                  dec_last_q, dec_last_d;
`ifdef VITERBI_TB_START_CHK_EN
  state_t                final_q, final_d;
`endif

  logic          push, pop;
  logic [LW-1:0] lifo_cnt;
  logic          lifo_empty, lifo_top;
  state_t        pred;

  assign pred = predecessor(cur_q, rd_data);

  tb_bit_lifo #(.DEPTH(DEPTH)) u_lifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .bit_i   (cur_q[K-2]),
    .pop_i   (pop),
    .count_o (lifo_cnt),
    .empty_o (lifo_empty),
    .top_o   (lifo_top)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    dec_bit_d   = dec_bit_q;
    dec_valid_d = dec_valid_q;
    dec_last_d  = dec_last_q;
    push        = 1'b0;
    pop         = 1'b0;
`ifdef VITERBI_TB_START_CHK_EN
    final_d     = final_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d = TRACE;
          cur_d   = start_state;
          addr_d  = last_addr;
          len_d   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
          cnt_d   = LW'(1);
`ifdef VITERBI_TB_START_CHK_EN
          final_d = '0;
`endif
        end
      end
      TRACE: begin
        // rd_data lags addr_rd by one cycle; the first TRACE cycle has nothing to consume.
        if (rd_vld_q) begin
          push  = 1'b1;
          cur_d = pred;
        end
        if (cnt_q == len_q) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q - 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        push    = 1'b1;
        cur_d   = pred;
        state_d = OUTPUT;
`ifdef VITERBI_TB_START_CHK_EN
        final_d = pred;
`endif
      end
      OUTPUT: begin
        if (dec_valid_q && dec_ready && dec_last_q) begin
          state_d     = IDLE;
          dec_valid_d = 1'b0;
          dec_last_d  = 1'b0;
        end else if ((!dec_valid_q || dec_ready) && !lifo_empty) begin
          pop         = 1'b1;
          dec_bit_d   = lifo_top;
          dec_valid_d = 1'b1;
          dec_last_d  = (lifo_cnt == LW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rd_vld_q    <= 1'b0;
      dec_bit_q   <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_last_q  <= 1'b0;
`ifdef VITERBI_TB_START_CHK_EN
      final_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rd_vld_q    <= (state_q == TRACE);
      dec_bit_q   <= dec_bit_d;
      dec_valid_q <= dec_valid_d;
      dec_last_q  <= dec_last_d;
`ifdef VITERBI_TB_START_CHK_EN
      final_q     <= final_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign addr_rd   = addr_q;
  assign dec_bit   = dec_bit_q;
  assign dec_valid = dec_valid_q;
  assign dec_last  = dec_last_q;
`ifdef VITERBI_TB_START_CHK_EN
  assign start_err = (final_q != '0);
`endif

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback: survivor RAM model plus a backward-trace reference.
module tb_viterbi_traceback;

  localparam int TK = 4;
  localparam int NS = 8;
  localparam int AW = 6;
  localparam int NA = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [TK-2:0] start_state;
  logic [AW-1:0] last_addr;
  logic [AW:0]   frame_len;
  logic          busy;
  logic [AW-1:0] addr_rd;
  logic [NS-1:0] rd_data;
  logic          dec_bit, dec_valid, dec_ready, dec_last;
`ifdef VITERBI_TB_START_CHK_EN
  logic          start_err;
`endif

  viterbi_traceback #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_state (start_state),
    .last_addr   (last_addr),
    .frame_len   (frame_len),
    .busy        (busy),
    .addr_rd     (addr_rd),
    .rd_data     (rd_data),
    .dec_bit     (dec_bit),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_last    (dec_last)
`ifdef VITERBI_TB_START_CHK_EN
    ,
    .start_err   (start_err)
`endif
  );

  always #5 clk = ~clk;

  // Survivor memory with a registered read port.
  logic [NS-1:0] ram [NA];
  always @(posedge clk) rd_data <= ram[addr_rd];

  int checks = 0;
  int errors = 0;

  int exp_addr[$], exp_bit[$];
  int exp_final;
  int got_addr[$], got_bit[$], got_last[$];
  int first_valid, stall_bad, stall_seen, busy_bad, post_valid, post_busy;
  bit timeout;

  task automatic fill_ram(input int mode);
    for (int a = 0; a < NA; a++)
      ram[a] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : NS'($urandom);
  endtask

  // Walk the trellis backwards from the end state; the decoded bit of each
  // stage is the state's MSB, and bits come out in forward (oldest-first) order.
  function automatic void ref_trace(input int ss, input int la, input int n);
    int s = ss;
    exp_addr.delete();
    exp_bit.delete();
    for (int i = 0; i < n; i++) begin
      int a = (la - i + NA) % NA;
      exp_addr.push_back(a);
      exp_bit.push_front((s >> (TK - 2)) & 1);
      s = ((s * 2) % NS) + ((ram[a] >> s) & 1);
    end
    exp_final = s;
  endfunction

  // Drives one frame and records addresses, output bits and handshake behaviour.
  task automatic run_frame(input int ss, input int la, input int fl, input int mode,
                           input int stall_idx, input bit poke);
    int neff, cyc, bit_idx, stall_left, edge_n;
    bit held, last_xfer;
    logic hb, hl;
    neff = (fl > NA) ? NA : fl;
    got_addr.delete(); got_bit.delete(); got_last.delete();
    timeout = 0; stall_bad = 0; stall_seen = 0; busy_bad = 0;
    first_valid = -1; post_valid = 1; post_busy = 1;
    held = 0; last_xfer = 0; bit_idx = 0; stall_left = 5; cyc = 0;
    hb = 1'b0; hl = 1'b0;
    dec_ready   = 1'b1;
    start       = 1'b1;
    start_state = (TK-1)'(ss);
    last_addr   = AW'(la);
    frame_len   = (AW+1)'(fl);
    @(posedge clk); #1;
    start       = 1'b0;
    start_state = (TK-1)'($urandom);
    last_addr   = AW'($urandom);
    frame_len   = (AW+1)'($urandom);
    edge_n = 0;
    got_addr.push_back(int'(addr_rd));
    for (int i = 1; i < neff; i++) begin
      @(posedge clk); #1;
      edge_n++;
      got_addr.push_back(int'(addr_rd));
      start = poke && (i == 1);
      if (dec_valid === 1'b1 && first_valid < 0) first_valid = edge_n;
    end
    start = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      edge_n++; cyc++;
      if (held) begin
        if (dec_valid !== 1'b1 || dec_bit !== hb || dec_last !== hl) stall_bad++;
        if (busy !== 1'b1) busy_bad++;
      end
      if (dec_valid === 1'b1 && first_valid < 0) first_valid = edge_n;
      if (last_xfer) begin
        post_valid = int'(dec_valid);
        post_busy  = int'(busy);
        break;
      end
      if (cyc > 400) begin
        timeout = 1;
        break;
      end
      if (dec_valid === 1'b1 && mode == 2 && bit_idx == stall_idx && stall_left > 0) begin
        dec_ready = 1'b0;
        stall_left--;
        stall_seen++;
      end else if (mode == 1) dec_ready = 1'($urandom_range(0, 1));
      else dec_ready = 1'b1;
      held = (dec_valid === 1'b1) && !dec_ready;
      hb = dec_bit;
      hl = dec_last;
      if (dec_valid === 1'b1 && dec_ready) begin
        got_bit.push_back(int'(dec_bit));
        got_last.push_back(int'(dec_last));
        bit_idx++;
        if (dec_last) last_xfer = 1;
      end
    end
    dec_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dec_ready = 1'b1;
    start_state = '0; last_addr = '0; frame_len = '0;
    fill_ram(0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
    checks++; if (dec_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", dec_last); end
    checks++; if (dec_bit !== 1'b0) begin errors++; $display("FAIL reset_bit: got %b want 0", dec_bit); end
    checks++; if (addr_rd !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr_rd); end
`ifdef VITERBI_TB_START_CHK_EN
    checks++; if (start_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", start_err); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero;
    int ea[4] = '{3, 2, 1, 0};
    int eb[4] = '{0, 1, 0, 1};
    fill_ram(0);
    run_frame(3'b101, 3, 4, 0, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL zero_timeout: got 1 want 0"); end
    checks++; if (got_bit.size() != 4) begin errors++; $display("FAIL zero_count: got %0d want 4", got_bit.size()); end
    for (int j = 0; j < 4 && j < got_bit.size(); j++) begin
      checks++;
      if (got_addr[j] != ea[j] || got_bit[j] != eb[j] || got_last[j] != int'(j == 3)) begin
        errors++;
        $display("FAIL zero_step%0d: got addr %0d bit %0d last %0d want %0d %0d %0d",
                 j, got_addr[j], got_bit[j], got_last[j], ea[j], eb[j], int'(j == 3));
      end
    end
    checks++; if (first_valid != 6) begin errors++; $display("FAIL zero_latency: got %0d want 6", first_valid); end
    checks++; if (post_valid != 0 || post_busy != 0) begin errors++; $display("FAIL zero_end: got valid %0d busy %0d want 0 0", post_valid, post_busy); end
`ifdef VITERBI_TB_START_CHK_EN
    checks++; if (start_err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", start_err); end
`endif
  endtask

  task automatic test_all_ones;
    int eb[4] = '{1, 0, 0, 0};
    fill_ram(1);
    run_frame(3'b000, 3, 4, 0, 0, 0);
    checks++; if (got_bit.size() != 4) begin errors++; $display("FAIL ones_count: got %0d want 4", got_bit.size()); end
    for (int j = 0; j < 4 && j < got_bit.size(); j++) begin
      checks++;
      if (got_bit[j] != eb[j] || got_last[j] != int'(j == 3)) begin
        errors++;
        $display("FAIL ones_bit%0d: got %0d last %0d want %0d %0d", j, got_bit[j], got_last[j], eb[j], int'(j == 3));
      end
    end
`ifdef VITERBI_TB_START_CHK_EN
    checks++; if (start_err !== 1'b1) begin errors++; $display("FAIL ones_err: got %b want 1", start_err); end
`endif
  endtask

  task automatic test_wrap;
    int ea[4] = '{1, 0, 63, 62};
    int ss = $urandom_range(0, NS - 1);
    fill_ram(2);
    ref_trace(ss, 1, 4);
    run_frame(ss, 1, 4, 0, 0, 0);
    for (int j = 0; j < 4 && j < got_addr.size(); j++) begin
      checks++; if (got_addr[j] != ea[j]) begin errors++; $display("FAIL wrap_addr%0d: got %0d want %0d", j, got_addr[j], ea[j]); end
    end
    checks++; if (first_valid != 6) begin errors++; $display("FAIL wrap_latency: got %0d want 6", first_valid); end
    checks++; if (got_bit != exp_bit) begin errors++; $display("FAIL wrap_bits: got %p want %p", got_bit, exp_bit); end
  endtask

  task automatic test_backpressure;
    int ss = $urandom_range(0, NS - 1);
    int la = $urandom_range(0, NA - 1);
    fill_ram(2);
    ref_trace(ss, la, 8);
    run_frame(ss, la, 8, 2, 2, 0);
    checks++; if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_len: got %0d want 5", stall_seen); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stall_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL bp_busy: got %0d drops want 0", busy_bad); end
    checks++; if (got_bit != exp_bit) begin errors++; $display("FAIL bp_bits: got %p want %p", got_bit, exp_bit); end
    checks++; if (got_last.sum() != 1 || got_last[$] != 1) begin errors++; $display("FAIL bp_last: got %p want only final", got_last); end
  endtask

  task automatic test_ignored_start;
    int ss = $urandom_range(0, NS - 1);
    int la = $urandom_range(0, NA - 1);
    start = 1'b1; frame_len = '0; last_addr = AW'(la);
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_start: got busy %b want 0", busy); end
    fill_ram(2);
    ref_trace(ss, la, 6);
    run_frame(ss, la, 6, 0, 0, 1);
    checks++; if (got_addr != exp_addr) begin errors++; $display("FAIL poke_addr: got %p want %p", got_addr, exp_addr); end
    checks++; if (got_bit != exp_bit) begin errors++; $display("FAIL poke_bits: got %p want %p", got_bit, exp_bit); end
    checks++; if (post_busy != 0) begin errors++; $display("FAIL poke_end: got busy %0d want 0", post_busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL poke_restart: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_midframe;
    int ss = $urandom_range(0, NS - 1);
    int la = $urandom_range(0, NA - 1);
    fill_ram(2);
    start = 1'b1; start_state = (TK-1)'($urandom); last_addr = AW'($urandom); frame_len = 7'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || dec_valid !== 1'b0 || dec_last !== 1'b0 || dec_bit !== 1'b0 || addr_rd !== '0) begin
      errors++;
      $display("FAIL mid_reset_outs: got busy %b valid %b last %b bit %b addr %0d want all 0",
               busy, dec_valid, dec_last, dec_bit, addr_rd);
    end
    ref_trace(ss, la, 6);
    run_frame(ss, la, 6, 0, 0, 0);
    checks++; if (got_bit != exp_bit) begin errors++; $display("FAIL mid_reset_bits: got %p want %p", got_bit, exp_bit); end
    checks++; if (got_last.sum() != 1 || got_last[$] != 1) begin errors++; $display("FAIL mid_reset_last: got %p want only final", got_last); end
  endtask

  task automatic test_full_frame;
    int ss = $urandom_range(0, NS - 1);
    fill_ram(2);
    ref_trace(ss, 63, 64);
    run_frame(ss, 63, 64, 1, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL full_timeout: got 1 want 0"); end
    checks++; if (got_addr != exp_addr) begin errors++; $display("FAIL full_addr: got %p want %p", got_addr, exp_addr); end
    checks++; if (got_bit != exp_bit) begin errors++; $display("FAIL full_bits: got %p want %p", got_bit, exp_bit); end
    checks++; if (got_last.sum() != 1 || got_last.size() != 64 || got_last[63] != 1) begin errors++; $display("FAIL full_last: got %0d marks over %0d bits want 1 on bit 64", got_last.sum(), got_last.size()); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL full_stable: got %0d changes want 0", stall_bad); end
`ifdef VITERBI_TB_START_CHK_EN
    checks++; if (start_err !== 1'(exp_final != 0)) begin errors++; $display("FAIL full_err: got %b want %0d", start_err, exp_final != 0); end
`endif
    ss = $urandom_range(0, NS - 1);
    ref_trace(ss, 20, 64);
    run_frame(ss, 20, 100, 0, 0, 0);
    checks++; if (got_bit.size() != 64) begin errors++; $display("FAIL clamp_count: got %0d want 64", got_bit.size()); end
    checks++; if (got_bit != exp_bit) begin errors++; $display("FAIL clamp_bits: got %p want %p", got_bit, exp_bit); end
  endtask

  task automatic test_random_frames;
    for (int f = 0; f < 6; f++) begin
      int ss = $urandom_range(0, NS - 1);
      int la = $urandom_range(0, NA - 1);
      int fl = $urandom_range(1, NA);
      fill_ram(2);
      ref_trace(ss, la, fl);
      run_frame(ss, la, fl, 1, 0, 0);
      checks++; if (got_addr != exp_addr) begin errors++; $display("FAIL rnd%0d_addr: got %p want %p", f, got_addr, exp_addr); end
      checks++; if (got_bit != exp_bit) begin errors++; $display("FAIL rnd%0d_bits: got %p want %p", f, got_bit, exp_bit); end
      checks++; if (first_valid != fl + 2) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", f, first_valid, fl + 2); end
      checks++; if (stall_bad != 0 || post_valid != 0) begin errors++; $display("FAIL rnd%0d_handshake: got %0d changes valid %0d want 0 0", f, stall_bad, post_valid); end
`ifdef VITERBI_TB_START_CHK_EN
      checks++; if (start_err !== 1'(exp_final != 0)) begin errors++; $display("FAIL rnd%0d_err: got %b want %0d", f, start_err, exp_final != 0); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_ones();
    test_wrap();
    test_backpressure();
    test_ignored_start();
    test_reset_midframe();
    test_full_frame();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
